// File: rtl/mbc1_bank_ctrl.sv
// MBC1 bank-register sequencer: synchronises the GB write strobe, commits one write per strobe
// and maps ROM/ext-RAM addresses. Define MBC1_EXT_RAM_EN to enable the external-RAM path.
module mbc1_bank_ctrl #(
  parameter int unsigned ROM_ADDR_W  = 19,
  parameter int unsigned RAM_ADDR_W  = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_n,
  input  logic                  cs_n,
  input  logic [15:0]           addr,
  input  logic [7:0]            data_in,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_sel,
  output logic                  ram_we,
  output logic                  reg_wr_pulse,
  output logic [4:0]            bank_lo,
  output logic [1:0]            bank_hi,
  output logic                  ram_en,
  output logic                  mode
);

  typedef enum logic [1:0] {StIdle, StSettle, StCommit, StRelease} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, cs_sync_q, vld_q;
  logic                   hist_q, hist_d;
  logic [2:0]             addr_q;
  logic [4:0]             data_q;
  logic [4:0]             bank_lo_q, bank_lo_d;
  logic [1:0]             bank_hi_q, bank_hi_d;
  logic                   ram_en_q, ram_en_d;
  logic                   mode_q, mode_d;
  logic                   we_c;
  logic                   wr_s, cs_s;
  logic [1:0]             hi_sel;
  logic [20:0]            rom_full;
  logic                   unused_data;

  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign unused_data = ^data_in[7:5];

  // History stays 0 until the chain holds real samples, so a strobe held low across reset
  // release never looks like a fresh falling edge.
  assign hist_d = vld_q[SYNC_STAGES-1] ? wr_s : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      wr_sync_q <= '1;
      cs_sync_q <= '1;
      vld_q     <= '0;
      hist_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      bank_lo_q <= 5'd1;
      bank_hi_q <= 2'd0;
      ram_en_q  <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_n};
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      hist_q    <= hist_d;
      addr_q    <= addr[15:13];
      data_q    <= data_in[4:0];
      bank_lo_q <= bank_lo_d;
      bank_hi_q <= bank_hi_d;
      ram_en_q  <= ram_en_d;
      mode_q    <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    reg_wr_pulse = 1'b0;
    we_c         = 1'b0;
    bank_lo_d    = bank_lo_q;
    bank_hi_d    = bank_hi_q;
    ram_en_d     = ram_en_q;
    mode_d       = mode_q;
    unique case (state_q)
      StIdle: begin
        if (hist_q && !wr_s) state_d = StSettle;
      end
      StSettle: begin
        state_d = wr_s ? StIdle : StCommit;
      end
      StCommit: begin
        reg_wr_pulse = 1'b1;
        state_d      = StRelease;
        case (addr_q)
          3'b000: ram_en_d  = (data_q[3:0] == 4'hA);
          3'b001: bank_lo_d = (data_q == 5'd0) ? 5'd1 : data_q;
          3'b010: bank_hi_d = data_q[1:0];
          3'b011: mode_d    = data_q[0];
          3'b101: we_c      = !cs_s && ram_en_q;
          default: ;
        endcase
      end
      StRelease: begin
        if (wr_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign hi_sel   = mode_q ? bank_hi_q : 2'b00;
  assign rom_full = addr[14] ? {bank_hi_q, bank_lo_q, addr[13:0]} : {hi_sel, 5'b0, addr[13:0]};
  assign rom_addr = rom_full[ROM_ADDR_W-1:0];

`ifdef MBC1_EXT_RAM_EN
  logic [14:0] ram_full;
  assign ram_full = {hi_sel, addr[12:0]};
  assign ram_addr = ram_full[RAM_ADDR_W-1:0];
  assign ram_sel  = ram_en_q && !cs_n && (addr[15:13] == 3'b101);
  assign ram_we   = we_c;
`else
  logic unused_ram;
  assign unused_ram = ^{cs_n, cs_s, we_c};
  assign ram_addr   = '0;
  assign ram_sel    = 1'b0;
  assign ram_we     = 1'b0;
`endif

  assign bank_lo = bank_lo_q;
  assign bank_hi = bank_hi_q;
  assign ram_en  = ram_en_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_mbc1_bank_ctrl.sv
// Randomised self-checking bench for mbc1_bank_ctrl against an arithmetic register/mapping model.
module tb_mbc1_bank_ctrl;

  localparam int unsigned Latency = 4;  // SYNC_STAGES + 2

  logic        clk, rst, wr_n, cs_n;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [18:0] rom_addr;
  logic [14:0] ram_addr;
  logic        ram_sel, ram_we, reg_wr_pulse, ram_en, mode;
  logic [4:0]  bank_lo;
  logic [1:0]  bank_hi;
  logic [20:0] rom_addr21;
  logic [14:0] ram_addr21;
  logic        ram_sel21, ram_we21, pulse21, ram_en21, mode21;
  logic [4:0]  bank_lo21;
  logic [1:0]  bank_hi21;

  int n_cmp = 0;
  int n_err = 0;
  int m_bank_lo, m_bank_hi, m_ram_en, m_mode;

  mbc1_bank_ctrl u_dut (
    .clk(clk), .rst(rst), .wr_n(wr_n), .cs_n(cs_n), .addr(addr), .data_in(data_in),
    .rom_addr(rom_addr), .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_we(ram_we),
    .reg_wr_pulse(reg_wr_pulse), .bank_lo(bank_lo), .bank_hi(bank_hi), .ram_en(ram_en),
    .mode(mode)
  );

  mbc1_bank_ctrl #(.ROM_ADDR_W(21)) u_dut21 (
    .clk(clk), .rst(rst), .wr_n(wr_n), .cs_n(cs_n), .addr(addr), .data_in(data_in),
    .rom_addr(rom_addr21), .ram_addr(ram_addr21), .ram_sel(ram_sel21), .ram_we(ram_we21),
    .reg_wr_pulse(pulse21), .bank_lo(bank_lo21), .bank_hi(bank_hi21), .ram_en(ram_en21),
    .mode(mode21)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ext_ram();
`ifdef MBC1_EXT_RAM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_rom(input int a);
    int hi;
    hi = (m_mode != 0) ? m_bank_hi : 0;
    if (a < 'h4000) return hi * 524288 + (a % 16384);
    return m_bank_hi * 524288 + m_bank_lo * 16384 + (a % 16384);
  endfunction

  function automatic int exp_ram(input int a);
    int hi;
    if (!ext_ram()) return 0;
    hi = (m_mode != 0) ? m_bank_hi : 0;
    return (hi * 8192 + (a % 8192)) % 32768;
  endfunction

  function automatic int exp_sel(input int a, input int cs);
    if (!ext_ram()) return 0;
    return (m_ram_en != 0 && cs == 0 && a >= 'hA000 && a < 'hC000) ? 1 : 0;
  endfunction

  // Applies one committed write to the model; returns the expected number of ram_we pulses.
  function automatic int model_write(input int a, input int d, input int cs);
    int we = 0;
    if (a < 'h2000) m_ram_en = ((d % 16) == 10) ? 1 : 0;
    else if (a < 'h4000) m_bank_lo = ((d % 32) == 0) ? 1 : (d % 32);
    else if (a < 'h6000) m_bank_hi = d % 4;
    else if (a < 'h8000) m_mode = d % 2;
    else if (a >= 'hA000 && a < 'hC000 && cs == 0 && m_ram_en != 0 && ext_ram()) we = 1;
    return we;
  endfunction

  task automatic model_reset();
    m_bank_lo = 1; m_bank_hi = 0; m_ram_en = 0; m_mode = 0;
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic cs, input int hold,
                        input logic [7:0] d2, output int npulse, output int first, output int nwe);
    addr = a; data_in = d; cs_n = cs;
    @(negedge clk);
    wr_n = 1'b0;
    npulse = 0; first = -1; nwe = 0;
    for (int i = 1; i <= hold + 8; i++) begin
      @(negedge clk);
      if (reg_wr_pulse) begin
        npulse++;
        if (first < 0) first = i;
      end
      if (ram_we) nwe++;
      if (i == 5) data_in = d2;
      if (i == hold) wr_n = 1'b1;
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic cs,
                          input int hold, input logic [7:0] d2);
    int np, fi, nw, ewe;
    strobe(a, d, cs, hold, d2, np, fi, nw);
    ewe = model_write(int'(a), int'(d), int'(cs));
    check_eq("pulse_count", np, 1);
    check_eq("pulse_latency", fi, Latency);
    check_eq("ram_we_count", nw, ewe);
    check_eq("bank_lo", bank_lo, m_bank_lo);
    check_eq("bank_hi", bank_hi, m_bank_hi);
    check_eq("ram_en", ram_en, m_ram_en);
    check_eq("mode", mode, m_mode);
  endtask

  task automatic check_map(input logic [15:0] a, input logic cs);
    addr = a; cs_n = cs;
    @(negedge clk);
    if (a < 16'h8000) begin
      check_eq("rom_addr", rom_addr, exp_rom(int'(a)) % 524288);
      check_eq("rom_addr21", rom_addr21, exp_rom(int'(a)));
    end
    check_eq("ram_addr", ram_addr, exp_ram(int'(a)));
    check_eq("ram_sel", ram_sel, exp_sel(int'(a), int'(cs)));
  endtask

  task automatic count_pulses(input int cycles, output int np);
    np = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (reg_wr_pulse) np++;
    end
  endtask

  initial begin
    int np;
    logic [15:0] ra;
    logic [7:0]  rd;
    rst = 1'b0; wr_n = 1'b1; cs_n = 1'b1; addr = 16'h4123; data_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state and default mapping
    check_eq("rst_bank_lo", bank_lo, 1);
    check_eq("rst_bank_hi", bank_hi, 0);
    check_eq("rst_mode", mode, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_pulse", reg_wr_pulse, 0);
    check_eq("rst_rom_4123", rom_addr, 19'h04123);

    // Bank 0 aliases to 1; bank 0x13 mapping
    do_write(16'h2000, 8'h00, 1'b1, 6, 8'h00);
    do_write(16'h2000, 8'h13, 1'b1, 6, 8'h13);
    addr = 16'h4000;
    @(negedge clk);
    check_eq("rom_4c000", rom_addr, 19'h4C000);

    // One-cycle glitch must not commit
    @(negedge clk); wr_n = 1'b0;
    @(negedge clk); wr_n = 1'b1;
    count_pulses(12, np);
    check_eq("glitch_pulses", np, 0);

    // Long strobe with data changed after commit: one commit, first data kept
    do_write(16'h2000, 8'h05, 1'b1, 50, 8'h1F);

    // External RAM enable, write and disable
    do_write(16'h0000, 8'h0A, 1'b1, 6, 8'h0A);
    do_write(16'hA010, 8'h55, 1'b0, 6, 8'h55);
    check_map(16'hA010, 1'b0);
    check_eq("ram_addr_0010", ram_addr, ext_ram() ? 15'h0010 : 15'h0000);
    do_write(16'h0000, 8'h00, 1'b1, 6, 8'h00);
    do_write(16'hA010, 8'h55, 1'b0, 6, 8'h55);
    check_map(16'hA010, 1'b0);

    // Mode 1 with upper bank 2
    do_write(16'h6000, 8'h01, 1'b1, 6, 8'h01);
    do_write(16'h4000, 8'h02, 1'b1, 6, 8'h02);
    check_map(16'h0100, 1'b1);
    check_eq("rom21_100100", rom_addr21, 21'h100100);
    check_map(16'hA000, 1'b0);
    check_eq("ram_4000", ram_addr, ext_ram() ? 15'h4000 : 15'h0000);
    cs_n = 1'b1;

    // Reset while strobe is low; release with strobe still low
    @(negedge clk); wr_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_pulses(12, np);
    check_eq("rst_held_pulses", np, 0);
    check_eq("rst_mid_bank_lo", bank_lo, 1);
    check_eq("rst_mid_mode", mode, 0);
    wr_n = 1'b1;
    repeat (4) @(negedge clk);
    do_write(16'h2000, 8'h07, 1'b1, 6, 8'h07);

    // Randomised writes and mapping probes
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: ra = 16'h0000;
        1: ra = 16'h2000;
        2: ra = 16'h4000;
        3: ra = 16'h6000;
        4: ra = 16'hA000;
        default: ra = 16'hC000;
      endcase
      ra = ra + 16'($urandom_range(0, 16'h1FFF));
      rd = 8'($urandom);
      if (ra < 16'h2000 && $urandom_range(0, 1) == 1) rd[3:0] = 4'hA;
      do_write(ra, rd, 1'($urandom_range(0, 1)), $urandom_range(4, 12), rd);
      check_map(16'($urandom), 1'($urandom_range(0, 1)));
      check_map(16'hA000 + 16'($urandom_range(0, 16'h1FFF)), 1'b0);
      cs_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
